// File: rtl/icache_line_fill.sv
// Instruction-cache line filler: reads four consecutive words from backing memory,
// assembles them into one line and pulses inputReady1 when the line is complete.
//
// state | meaning
// IDLE  | waiting for read_m1; the line base is latched here
// ISSUE | one-cycle mem_read for word idx
// WAIT  | waiting for mem_rvalid carrying word idx
// DONE  | line complete, inputReady1 high for this cycle
module icache_line_fill #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            read_m1,
    input  logic [WORD_SIZE-1:0]            address1,
    output logic [LINE_WORDS*WORD_SIZE-1:0] data1,
    output logic                            inputReady1,
    output logic                            mem_read,
    output logic [WORD_SIZE-1:0]            mem_addr,
    input  logic [WORD_SIZE-1:0]            mem_rdata,
    input  logic                            mem_rvalid,
    output logic                            busy,
    output logic [CNT_WIDTH-1:0]            fill_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = {{(WORD_SIZE-2){1'b1}}, 2'b00};

    state_t                               state_q, state_d;
    logic [WORD_SIZE-1:0]                 base_q, base_d;
    logic [1:0]                           idx_q, idx_d;
    logic [LINE_WORDS-1:0][WORD_SIZE-1:0] line_q, line_d;
    logic [CNT_WIDTH-1:0]                 cnt_q, cnt_d;
    logic                                 ready_q, ready_d;
    logic                                 mem_read_q, mem_read_d;
    logic [WORD_SIZE-1:0]                 mem_addr_q, mem_addr_d;
    logic                                 busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        line_d  = line_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (read_m1) begin
                    base_d  = address1 & ALIGN_MASK;
                    idx_d   = 2'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mem_rvalid) begin
                    line_d[idx_q] = mem_rdata;
                    if (idx_q == 2'd3) begin
                        state_d = DONE;
                        // Counter moves on DONE entry so it is current in the ready cycle.
                        if (~&cnt_q) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state; the offset is OR-ed into an
        // aligned base so the address can never carry out of the line.
        mem_read_d = (state_d == ISSUE);
        mem_addr_d = (state_d == ISSUE) ? (base_d | {{(WORD_SIZE-2){1'b0}}, idx_d}) : mem_addr_q;
        ready_d    = (state_d == DONE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            idx_q      <= '0;
            line_q     <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            line_q     <= line_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
        end
    end

    assign data1       = line_q;
    assign inputReady1 = ready_q;
    assign mem_read    = mem_read_q;
    assign mem_addr    = mem_addr_q;
    assign busy        = busy_q;
    assign fill_count  = cnt_q;

endmodule

// File: tb/tb_icache_line_fill.sv
// Bench for icache_line_fill: transaction-level line-fill model checked every cycle,
// directed scenarios pinned by literal values, then a randomized run.
module tb_icache_line_fill;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        read_m1    = 1'b0;
    logic [15:0] address1   = '0;
    logic [15:0] mem_rdata  = '0;
    logic        mem_rvalid = 1'b0;

    logic [63:0] data1, data1_s;
    logic        inputReady1, ready_s, mem_read, mem_read_s, busy, busy_s;
    logic [15:0] mem_addr, mem_addr_s, fill_count;
    logic [1:0]  fill_count_s;

    icache_line_fill #(.WORD_SIZE(16), .LINE_WORDS(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .read_m1(read_m1), .address1(address1),
        .data1(data1), .inputReady1(inputReady1), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy), .fill_count(fill_count)
    );

    // Narrow-counter copy sharing all inputs, used to see saturation quickly.
    icache_line_fill #(.WORD_SIZE(16), .LINE_WORDS(4), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .read_m1(read_m1), .address1(address1),
        .data1(data1_s), .inputReady1(ready_s), .mem_read(mem_read_s), .mem_addr(mem_addr_s),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy_s), .fill_count(fill_count_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Backing memory: answers each mem_read after a latency, optionally spurious rvalids when idle.
    bit          directed    = 1'b1;
    bit          spurious_en = 1'b0;
    int          mem_lat     = 2;
    int          stall_off   = -1;
    int          pend        = 0;
    logic [1:0]  pend_off    = '0;

    always @(posedge clk) begin
        #1;
        mem_rvalid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = directed ? (16'hA000 | {14'd0, pend_off}) : 16'($urandom);
            end
        end else if (!mem_read && spurious_en && $urandom_range(0, 1) == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'($urandom);
        end
        if (mem_read) begin
            pend_off = mem_addr[1:0];
            if (directed)
                pend = (int'(mem_addr[1:0]) == stall_off) ? 22 : mem_lat;
            else
                pend = ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(1, 4));
        end
    end

    // Reference model: one fill = accept, then four read/response pairs, then a ready cycle.
    bit          m_active = 0, m_read = 0, m_ready = 0, m_wait = 0, n_read = 0, n_ready = 0;
    int          m_words = 0, m_cnt = 0;
    logic [15:0] m_base = '0, m_addr = '0;
    logic [15:0] m_line [4] = '{default: '0};
    int          req_cyc = 0, ready_cyc = 0, ready_count = 0;
    logic [15:0] addr_log [$];

    always @(negedge clk) begin
        if (!reset_n) begin
            m_active = 0; m_read = 0; m_ready = 0; m_wait = 0;
            m_words  = 0; m_cnt  = 0; m_base  = '0; m_addr = '0;
            for (int k = 0; k < 4; k++) m_line[k] = '0;
        end
        chk("busy", busy, m_active);
        chk("mem_read", mem_read, m_read);
        chk("mem_addr", mem_addr, m_addr);
        chk("ready", inputReady1, m_ready);
        chk("data1", data1, {m_line[3], m_line[2], m_line[1], m_line[0]});
        chk("fill_count", fill_count, sat(m_cnt, 65535));
        chk("sat_busy", busy_s, m_active);
        chk("sat_mem_read", mem_read_s, m_read);
        chk("sat_mem_addr", mem_addr_s, m_addr);
        chk("sat_ready", ready_s, m_ready);
        chk("sat_data1", data1_s, {m_line[3], m_line[2], m_line[1], m_line[0]});
        chk("sat_fill_count", fill_count_s, sat(m_cnt, 3));
        if (reset_n) begin
            if (mem_read) addr_log.push_back(mem_addr);
            if (inputReady1) begin
                ready_cyc = cyc;
                ready_count++;
            end
            n_read  = 0;
            n_ready = 0;
            if (!m_active) begin
                if (read_m1) begin
                    m_active = 1;
                    m_base   = address1 & 16'hFFFC;
                    m_words  = 0;
                    m_wait   = 0;
                    m_addr   = m_base;
                    n_read   = 1;
                    req_cyc  = cyc;
                end
            end else if (m_ready) begin
                m_active = 0;
            end else if (m_read) begin
                m_wait = 1;
            end else if (m_wait && mem_rvalid) begin
                m_line[m_words] = mem_rdata;
                m_words++;
                m_wait = 0;
                if (m_words == 4) begin
                    n_ready = 1;
                    m_cnt++;
                end else begin
                    n_read = 1;
                    m_addr = m_base + 16'(m_words);
                end
            end
            m_read  = n_read;
            m_ready = n_ready;
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_point();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_ready(input int limit, input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            sample_point();
            if (inputReady1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: no inputReady1 within %0d cycles", nm, limit);
        end
    endtask

    task automatic request(input logic [15:0] a);
        drive_edge();
        read_m1  = 1'b1;
        address1 = a;
        drive_edge();
        read_m1  = 1'b0;
    endtask

    task automatic chk_log(input string nm, input logic [15:0] base);
        chk({nm, "_count"}, 64'(addr_log.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            if (addr_log.size() > k) chk(nm, addr_log[k], base + 16'(k));
    endtask

    localparam logic [63:0] DIRECTED_LINE = 64'hA003A002A001A000;

    initial begin
        int rc;
        reset_n  = 1'b0;
        read_m1  = 1'b1;
        address1 = 16'h0106;
        repeat (3) sample_point();
        chk("reset_busy", busy, 0);
        chk("reset_data1", data1, 0);
        chk("reset_mem_read", mem_read, 0);
        chk("reset_ready", inputReady1, 0);
        chk("reset_count", fill_count, 0);

        // Basic fill: request already high when reset releases.
        drive_edge();
        reset_n = 1'b1;
        drive_edge();
        read_m1 = 1'b0;
        sample_point();
        chk("first_issue", mem_read, 1);
        chk("first_addr", mem_addr, 16'h0104);
        wait_ready(40, "basic_ready");
        chk("basic_data", data1, DIRECTED_LINE);
        chk("basic_latency", 64'(ready_cyc - req_cyc), 64'd13);
        chk("basic_count", fill_count, 1);
        chk_log("basic_addr", 16'h0104);
        sample_point();
        chk("ready_one_cycle", inputReady1, 0);

        // Spurious rvalid while idle.
        drive_edge();
        spurious_en = 1'b1;
        repeat (20) drive_edge();
        spurious_en = 1'b0;
        drive_edge();
        chk("spurious_data1", data1, DIRECTED_LINE);
        chk("spurious_idle", busy, 0);

        // Stalled memory on word 2.
        addr_log.delete();
        stall_off = 2;
        request(16'h0104);
        wait_ready(120, "stall_ready");
        chk("stall_data", data1, DIRECTED_LINE);
        chk_log("stall_addr", 16'h0104);
        chk("stall_count", fill_count, 2);
        stall_off = -1;

        // read_m1 toggling mid-fill with another address.
        addr_log.delete();
        drive_edge();
        read_m1  = 1'b1;
        address1 = 16'h0104;
        for (int i = 0; i < 6; i++) begin
            drive_edge();
            read_m1  = ~read_m1;
            address1 = 16'h0300;
        end
        drive_edge();
        read_m1 = 1'b0;
        wait_ready(40, "ignored_ready");
        chk_log("ignored_addr", 16'h0104);
        chk("ignored_count", fill_count, 3);
        repeat (4) sample_point();
        chk("ignored_idle", busy, 0);
        chk("ignored_no_extra", fill_count, 3);
        chk("sat_at_3", fill_count_s, 3);

        // Fourth fill: narrow counter holds at its ceiling.
        request(16'h0208);
        wait_ready(40, "sat_ready");
        chk("sat_holds", fill_count_s, 3);
        chk("count_4", fill_count, 4);

        // Reset during WAIT of word 1; the pending response lands after release.
        addr_log.delete();
        mem_lat = 4;
        request(16'h0104);
        for (int i = 0; i < 40 && addr_log.size() < 2; i++) sample_point();
        chk("midfill_reached", 64'(addr_log.size()), 64'd2);
        rc = ready_count;
        drive_edge();
        reset_n = 1'b0;
        sample_point();
        chk("midfill_rst_busy", busy, 0);
        chk("midfill_rst_count", fill_count, 0);
        drive_edge();
        drive_edge();
        reset_n = 1'b1;
        repeat (8) sample_point();
        chk("midfill_no_ready", 64'(ready_count), 64'(rc));
        chk("midfill_count", fill_count, 0);

        // Address wrap at the top of memory.
        mem_lat = 2;
        addr_log.delete();
        request(16'hFFFE);
        wait_ready(40, "wrap_ready");
        chk_log("wrap_addr", 16'hFFFC);
        chk("wrap_data", data1, DIRECTED_LINE);
        chk("wrap_count", fill_count, 1);

        // Randomized traffic.
        directed    = 1'b0;
        spurious_en = 1'b1;
        rc = ready_count;
        for (int i = 0; i < 3000; i++) begin
            drive_edge();
            read_m1  = ($urandom_range(0, 3) == 0);
            address1 = 16'($urandom);
        end
        read_m1     = 1'b0;
        spurious_en = 1'b0;
        for (int i = 0; i < 200 && busy; i++) sample_point();
        sample_point();
        chk("final_idle", busy, 0);
        chk("random_fills", 64'(ready_count - rc > 20), 64'd1);
        chk("final_sat", fill_count_s, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/icache_line_fill.md
Name: icache_line_fill

Overview:
- Sits directly downstream of the instruction cache, between its miss port and the word-wide backing instruction memory.
- Accepts one line-fill request: a 16-bit word address and a read strobe.
- Issues 4 sequential single-word reads to backing memory and assembles them into a 4-word line.
- Returns the line with a one-cycle ready pulse, and keeps a saturating count of completed fills for performance monitoring.

Parameters:
- WORD_SIZE, 16, width of one word and of all addresses.
- LINE_WORDS, 4, words per cache line; fixed at 4, and the offset field is 2 bits.
- CNT_WIDTH, 16, width of the fill counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- read_m1  in  1  fill request from the instruction cache.
- address1  in  WORD_SIZE  request address; the low 2 bits are ignored.
- data1  out  LINE_WORDS*WORD_SIZE  assembled line; word at offset k occupies bits [16k+15:16k].
- inputReady1  out  1  one-cycle pulse: data1 holds the complete line.
- mem_read  out  1  one-cycle read strobe to backing memory.
- mem_addr  out  WORD_SIZE  backing-memory word address.
- mem_rdata  in  WORD_SIZE  backing-memory read data.
- mem_rvalid  in  1  mem_rdata is valid this cycle; at most one per mem_read.
- busy  out  1  a fill is in progress (any state other than IDLE).
- fill_count  out  CNT_WIDTH  number of completed fills, saturating.

Behaviour:
- Reset, asynchronous while reset_n=0:
  - State = IDLE.
  - data1=0, inputReady1=0, mem_read=0, mem_addr=0, busy=0, fill_count=0, word index=0, base=0.
- Reset mid-fill: the fill is abandoned immediately, no ready pulse is produced, and a late mem_rvalid after reset release is ignored in IDLE.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If read_m1=1, latch base={address1[15:2],2'b00} and set idx=0, then go to ISSUE.
  - read_m1 is sampled only in IDLE; it is ignored in every other state.
- ISSUE:
  - Drive mem_read=1 and mem_addr=base+idx for exactly one cycle, then go to WAIT.
  - The +idx touches only the low 2 bits, so the address never crosses the line.
- WAIT:
  - On mem_rvalid=1, write mem_rdata into line word idx.
  - If idx==3, go to DONE; otherwise idx<=idx+1 and go to ISSUE.
  - Stay in WAIT indefinitely while mem_rvalid=0; there is no timeout.
- DONE:
  - inputReady1=1 for exactly this one cycle.
  - Increment fill_count unless it is all-ones; it saturates at 2^CNT_WIDTH-1.
  - Go to IDLE.
- Latency:
  - With backing-memory latency L (mem_rvalid L cycles after mem_read, L>=1), the ready pulse occurs 4*(L+1)+1 cycles after the request is sampled in IDLE.
  - The minimum back-to-back interval between ready pulses is 4*(L+1)+2 cycles.
- data1 holds its value after DONE until the next fill overwrites individual words. Its contents are defined only in the inputReady1 cycle.
- mem_addr holds its last driven value outside ISSUE. Only mem_read qualifies it.
- Requester rule: the instruction cache deasserts read_m1 no later than the cycle inputReady1=1. If read_m1 is still high in the IDLE cycle after DONE, a new fill of the then-current address1 starts. This is legal and counted.
- mem_rvalid arriving in IDLE, ISSUE or DONE is ignored.
- Address wrap: for a base of 0xFFFC, the fill reads 0xFFFC..0xFFFF with no carry out.

Test Plan:
- Reset: hold reset_n=0 with read_m1=1 -> all outputs 0 and state IDLE. Release reset -> the first fill starts on the next edge.
- Basic fill, L=2, read_m1 pulse with address1=0x0106:
  - mem_addr sequence 0x0104,0x0105,0x0106,0x0107.
  - Memory returns 0xA000..0xA003.
  - data1=0xA003A002A001A000 with a one-cycle inputReady1 at cycle 13 after the request.
  - fill_count=1.
- Stalled memory: hold mem_rvalid=0 for 20 cycles on word 2 -> busy stays 1, mem_read does not repeat, and the line completes correctly once rvalid arrives.
- Ignored inputs:
  - read_m1 toggled with address1=0x0300 mid-fill -> the current line for 0x0104 completes and no extra fill occurs.
  - A spurious mem_rvalid in IDLE -> data1 is unchanged.
- Reset mid-fill: assert reset_n=0 during WAIT of word 1 -> no inputReady1 pulse, fill_count stays at its prior value (0 after reset), and a subsequent fill of 0xFFFE reads 0xFFFC..0xFFFF.
- Saturation: preload by running fills with CNT_WIDTH=2 -> fill_count reaches 3 and stays 3 after a 4th fill.
